alu_share_arbiter: RTL

//  Shares one combinational 32-bit ALU instance between two requesters (req0, req1).

---
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one external ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             grant0, grant1;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
  end

  // Next-state and datapath: latch operands on accept, capture ALU output one cycle later.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    res_d      = res_q;
    zero_d     = zero_q;
    owner_d    = owner_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          alu_a_d    = req0_a;
          alu_b_d    = req0_b;
          alu_ctrl_d = req0_op;
          owner_d    = 1'b0;
          last_d     = 1'b0;
          state_d    = EXEC;
        end else if (grant1) begin
          alu_a_d    = req1_a;
          alu_b_d    = req1_b;
          alu_ctrl_d = req1_op;
          owner_d    = 1'b1;
          last_d     = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if ((~owner_q & rsp0_ready) | (owner_q & rsp1_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
    end
  end

  // Handshake outputs: readies only in IDLE, responses only in RESP for the owner.
  always_comb begin
    req0_ready = ~rst & (state_q == IDLE) & grant0;
    req1_ready = ~rst & (state_q == IDLE) & grant1;
    rsp0_valid = (state_q == RESP) & ~owner_q;
    rsp1_valid = (state_q == RESP) & owner_q;
    busy       = (state_q != IDLE);
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

endmodule
